decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 61 ++++++
 rtl/decode_stage_imm_gen.sv | 31 +++
 rtl/decode_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, immediate formats,
// default sizes and the ID/EX control-field struct.
package decode_stage_pkg;

    localparam int N_DEFAULT     = 5;
    localparam int WIDTH_DEFAULT = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_load;
        logic       reg_write;
    } idex_ctrl_t;

    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode == OP_LUI)  || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
               (opcode == OP_JALR) || (opcode == OP_LOAD)  || (opcode == OP_IMM) ||
               (opcode == OP_OP);
    endfunction

    // Unknown opcodes are treated as reading rs1 so hazards err on the safe side.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_OP);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// sign-extends from instruction bit 31.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_instr,
    output logic [WIDTH-1:0] o_imm
);

    logic [31:0] w_ins;
    logic [31:0] w_imm32;

    assign w_ins = i_instr[31:0];

    always_comb begin
        w_imm32 = '0;
        case (imm_format(w_ins[6:0]))
            FMT_I:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            FMT_S:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            FMT_B:   w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            FMT_U:   w_imm32 = {w_ins[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = WIDTH'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register-file read with writeback bypass,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             in_ready,
    output logic [N-1:0]     rf_a,
    output logic [N-1:0]     rf_b,
    input  logic [WIDTH-1:0] rf_data_a,
    input  logic [WIDTH-1:0] rf_data_b,
    input  logic             wb_wenable,
    input  logic [N-1:0]     wb_reg,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_rs1_val,
    output logic [WIDTH-1:0] out_rs2_val,
    output logic [WIDTH-1:0] out_imm,
    output logic [N-1:0]     out_rs1,
    output logic [N-1:0]     out_rs2,
    output logic [N-1:0]     out_rd,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic             out_is_load,
    output logic             out_reg_write
);

    logic [6:0]       w_opcode;
    logic [N-1:0]     w_rs1;
    logic [N-1:0]     w_rs2;
    logic [N-1:0]     w_rd;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    idex_ctrl_t       w_ctrl;
    logic             w_hazard;
    logic             w_out_ready_eff;

    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_rs1_val;
    logic [WIDTH-1:0] r_rs2_val;
    logic [WIDTH-1:0] r_imm;
    logic [N-1:0]     r_rs1;
    logic [N-1:0]     r_rs2;
    logic [N-1:0]     r_rd;
    idex_ctrl_t       r_ctrl;

    assign w_opcode = in_instr[6:0];
    assign w_rs1    = in_instr[15 +: N];
    assign w_rs2    = in_instr[20 +: N];
    assign w_rd     = in_instr[7 +: N];
    assign rf_a     = w_rs1;
    assign rf_b     = w_rs2;

    decode_stage_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .i_instr (in_instr),
        .o_imm   (w_imm)
    );

    // x0 reads as zero even if writeback targets it in the same cycle.
    always_comb begin
        w_rs1_val = rf_data_a;
        if (w_rs1 == '0)
            w_rs1_val = '0;
        else if (wb_wenable && (wb_reg == w_rs1))
            w_rs1_val = wb_data;

        w_rs2_val = rf_data_b;
        if (w_rs2 == '0)
            w_rs2_val = '0;
        else if (wb_wenable && (wb_reg == w_rs2))
            w_rs2_val = wb_data;
    end

    always_comb begin
        w_ctrl.opcode    = w_opcode;
        w_ctrl.funct3    = in_instr[14:12];
        w_ctrl.funct7    = in_instr[31:25];
        w_ctrl.is_load   = (w_opcode == OP_LOAD);
        w_ctrl.reg_write = writes_rd(w_opcode) && (w_rd != '0);
    end

    assign w_hazard = r_valid && r_ctrl.is_load && (r_rd != '0) &&
                      ((uses_rs1(w_opcode) && (r_rd == w_rs1)) ||
                       (uses_rs2(w_opcode) && (r_rd == w_rs2)));

    assign w_out_ready_eff = !r_valid || out_ready;
    assign in_ready        = flush || (w_out_ready_eff && !w_hazard);

    // Flush beats everything; a stall holds all fields; a hazard or empty input inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else if (flush) begin
            r_valid          <= 1'b0;
            r_ctrl.is_load   <= 1'b0;
            r_ctrl.reg_write <= 1'b0;
        end else if (w_out_ready_eff) begin
            if (in_valid && !w_hazard) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rd      <= w_rd;
                r_ctrl    <= w_ctrl;
            end else begin
                r_valid          <= 1'b0;
                r_ctrl.is_load   <= 1'b0;
                r_ctrl.reg_write <= 1'b0;
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_rs1_val   = r_rs1_val;
    assign out_rs2_val   = r_rs2_val;
    assign out_imm       = r_imm;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rd        = r_rd;
    assign out_opcode    = r_ctrl.opcode;
    assign out_funct3    = r_ctrl.funct3;
    assign out_funct7    = r_ctrl.funct7;
    assign out_is_load   = r_ctrl.is_load;
    assign out_reg_write = r_ctrl.reg_write;

endmodule
